// File: rtl/aos_sr_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aos_sr_responder_pkg -- shared types for the SoftReg app-side responder    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package aos_sr_responder_pkg;

  localparam int          SR_IDX_MAX_W    = 16;
  localparam logic [63:0] SR_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {SR_CONFIG = 1'b0, SR_APP = 1'b1} sr_region_t;
  typedef enum logic {SR_IDLE = 1'b0, SR_APP_WAIT = 1'b1} sr_resp_state_t;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  typedef struct packed {
    logic                    isApp;
    logic [SR_IDX_MAX_W-1:0] idx;
    logic [63:0]             snap;
  } SRPendEntry;

endpackage
`default_nettype wire

// File: rtl/aos_sr_responder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aos_sr_responder_fifo -- pending-read queue; full queue accepts on pop     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aos_sr_responder_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] deq_data,
  output logic             full,
  output logic             empty
);
  localparam int               DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] CNT_FULL = (LOG_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_enq, do_deq;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign do_deq   = deq && !empty;
  assign do_enq   = enq && (!full || do_deq);
  assign deq_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule
`default_nettype wire

// File: rtl/aos_sr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aos_sr_responder -- SoftReg endpoint: config bank plus in-order app reads  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aos_sr_responder
  import aos_sr_responder_pkg::*;
#(
  parameter int  NUM_REGS       = 16,
  parameter int  PEND_LOG_DEPTH = 2,
  parameter int  APP_TIMEOUT    = 255,
  localparam int IDX_W          = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  SoftRegReq                 sr_req,
  output SoftRegResp                sr_resp,
  output logic [NUM_REGS-1:0][63:0] cfg_regs,
  output logic                      app_wr_valid,
  output logic [IDX_W-1:0]          app_wr_idx,
  output logic [63:0]               app_wr_data,
  output logic                      app_rd_valid,
  output logic [IDX_W-1:0]          app_rd_idx,
  input  logic                      app_rd_ack,
  input  logic [63:0]               app_rd_data,
  output logic                      err_sticky,
  output logic [15:0]               drop_count
);
  localparam int               TMR_W   = $clog2(APP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(APP_TIMEOUT);

  logic [NUM_REGS-1:0][63:0] cfg_q, cfg_d;
  SoftRegResp                resp_q, resp_d;
  logic                      app_wr_valid_q, app_wr_valid_d;
  logic [IDX_W-1:0]          app_wr_idx_q, app_wr_idx_d;
  logic [63:0]               app_wr_data_q, app_wr_data_d;
  logic                      app_rd_valid_q, app_rd_valid_d;
  logic [IDX_W-1:0]          app_rd_idx_q, app_rd_idx_d;
  logic                      err_q, err_d;
  logic [15:0]               drop_q, drop_d;
  sr_resp_state_t            state_q, state_d;
  logic [TMR_W-1:0]          timer_q, timer_d;

  logic [IDX_W-1:0] req_idx;
  sr_region_t       req_region;
  logic             req_oor, rd_req, enq, pop, fifo_full, fifo_empty;
  SRPendEntry       enq_entry, head_entry;
  logic             unused_head_idx;

  assign req_idx         = sr_req.addr[IDX_W-1:0];
  assign req_region      = sr_region_t'(sr_req.addr[IDX_W]);
  assign req_oor         = |sr_req.addr[31:IDX_W+1];
  assign rd_req          = sr_req.valid && !sr_req.isWrite;
  // A pop in the same cycle frees a slot in a full queue.
  assign enq             = rd_req && (!fifo_full || pop);
  assign unused_head_idx = ^head_entry.idx;

  always_comb begin
    cfg_d          = cfg_q;
    app_wr_valid_d = 1'b0;
    app_wr_idx_d   = app_wr_idx_q;
    app_wr_data_d  = app_wr_data_q;
    if (sr_req.valid && sr_req.isWrite && !req_oor) begin
      if (req_region == SR_CONFIG) begin
        cfg_d[req_idx] = sr_req.data;
      end else begin
        app_wr_valid_d = 1'b1;
        app_wr_idx_d   = req_idx;
        app_wr_data_d  = sr_req.data;
      end
    end
  end

  always_comb begin
    enq_entry                  = '0;
    enq_entry.isApp            = !req_oor && (req_region == SR_APP);
    enq_entry.idx[IDX_W-1:0]   = req_idx;
    if (!req_oor && (req_region == SR_CONFIG)) enq_entry.snap = cfg_q[req_idx];
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    pop            = 1'b0;
    resp_d.valid   = 1'b0;
    resp_d.data    = resp_q.data;
    app_rd_valid_d = app_rd_valid_q;
    app_rd_idx_d   = app_rd_idx_q;
    err_d          = err_q;
    drop_d         = drop_q;
    case (state_q)
      SR_IDLE: begin
        if (!fifo_empty) begin
          if (head_entry.isApp) begin
            app_rd_valid_d = 1'b1;
            app_rd_idx_d   = head_entry.idx[IDX_W-1:0];
            timer_d        = '0;
            state_d        = SR_APP_WAIT;
          end else begin
            pop          = 1'b1;
            resp_d.valid = 1'b1;
            resp_d.data  = head_entry.snap;
          end
        end
      end
      SR_APP_WAIT: begin
        if (app_rd_ack) begin
          pop            = 1'b1;
          resp_d.valid   = 1'b1;
          resp_d.data    = app_rd_data;
          app_rd_valid_d = 1'b0;
          state_d        = SR_IDLE;
        end else if (timer_q == TMR_MAX) begin
          pop            = 1'b1;
          resp_d.valid   = 1'b1;
          resp_d.data    = SR_TIMEOUT_DATA;
          err_d          = 1'b1;
          app_rd_valid_d = 1'b0;
          state_d        = SR_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = SR_IDLE;
    endcase
    if (rd_req && fifo_full && !pop) begin
      err_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q          <= '0;
      resp_q         <= '0;
      app_wr_valid_q <= 1'b0;
      app_wr_idx_q   <= '0;
      app_wr_data_q  <= '0;
      app_rd_valid_q <= 1'b0;
      app_rd_idx_q   <= '0;
      err_q          <= 1'b0;
      drop_q         <= '0;
      state_q        <= SR_IDLE;
      timer_q        <= '0;
    end else begin
      cfg_q          <= cfg_d;
      resp_q         <= resp_d;
      app_wr_valid_q <= app_wr_valid_d;
      app_wr_idx_q   <= app_wr_idx_d;
      app_wr_data_q  <= app_wr_data_d;
      app_rd_valid_q <= app_rd_valid_d;
      app_rd_idx_q   <= app_rd_idx_d;
      err_q          <= err_d;
      drop_q         <= drop_d;
      state_q        <= state_d;
      timer_q        <= timer_d;
    end
  end

  aos_sr_responder_fifo #(
    .WIDTH     ($bits(SRPendEntry)),
    .LOG_DEPTH (PEND_LOG_DEPTH)
  ) u_pend_fifo (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq),
    .enq_data (enq_entry),
    .deq      (pop),
    .deq_data (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sr_resp      = resp_q;
  assign cfg_regs     = cfg_q;
  assign app_wr_valid = app_wr_valid_q;
  assign app_wr_idx   = app_wr_idx_q;
  assign app_wr_data  = app_wr_data_q;
  assign app_rd_valid = app_rd_valid_q;
  assign app_rd_idx   = app_rd_idx_q;
  assign err_sticky   = err_q;
  assign drop_count   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_aos_sr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aos_sr_responder -- directed scenarios plus randomized model comparison |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_aos_sr_responder;
  import aos_sr_responder_pkg::*;

  localparam int NUM_REGS  = 16;
  localparam int LOG_DEPTH = 2;
  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int TIMEOUT   = 255;
  localparam int N_RAND    = 400;

  typedef struct {
    bit          is_app;
    int          idx;
    logic [63:0] data;
  } pend_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  SoftRegReq                 sr_req;
  SoftRegResp                sr_resp;
  logic [NUM_REGS-1:0][63:0] cfg_regs;
  logic                      app_wr_valid;
  logic [3:0]                app_wr_idx;
  logic [63:0]               app_wr_data;
  logic                      app_rd_valid;
  logic [3:0]                app_rd_idx;
  logic                      app_rd_ack = 1'b0;
  logic [63:0]               app_rd_data = '0;
  logic                      err_sticky;
  logic [15:0]               drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aos_sr_responder #(
    .NUM_REGS       (NUM_REGS),
    .PEND_LOG_DEPTH (LOG_DEPTH),
    .APP_TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sr_req       (sr_req),
    .sr_resp      (sr_resp),
    .cfg_regs     (cfg_regs),
    .app_wr_valid (app_wr_valid),
    .app_wr_idx   (app_wr_idx),
    .app_wr_data  (app_wr_data),
    .app_rd_valid (app_rd_valid),
    .app_rd_idx   (app_rd_idx),
    .app_rd_ack   (app_rd_ack),
    .app_rd_data  (app_rd_data),
    .err_sticky   (err_sticky),
    .drop_count   (drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [63:0] d);
    sr_req.valid   = 1'b1;
    sr_req.isWrite = wr;
    sr_req.addr    = a;
    sr_req.data    = d;
    tick();
    sr_req = '0;
  endtask

  task automatic do_reset();
    sr_req = '0; app_rd_ack = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_app_valid(input string name);
    int k = 0;
    while (!app_rd_valid && k < 20) begin tick(); k++; end
    n_checks++;
    if (!app_rd_valid) begin n_fail++; $display("FAIL %s: app_rd_valid got 0 required 1 within 20 cycles", name); end
  endtask

  task automatic test_reset();
    sr_req = '0; app_rd_ack = 1'b0; rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (sr_resp !== '0) begin n_fail++; $display("FAIL reset_resp: got %h required 0", sr_resp); end
    n_checks++; if (cfg_regs !== '0) begin n_fail++; $display("FAIL reset_cfg: got nonzero required 0"); end
    n_checks++; if ({app_wr_valid, app_rd_valid, err_sticky} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {app_wr_valid, app_rd_valid, err_sticky}); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_config();
    int idx; logic [63:0] d;
    send(1'b1, 32'h3, 64'hA5);
    n_checks++; if (cfg_regs[3] !== 64'hA5) begin n_fail++; $display("FAIL cfg_write: got %h required a5", cfg_regs[3]); end
    send(1'b0, 32'h3, 64'h0);
    n_checks++; if (sr_resp.valid !== 1'b0) begin n_fail++; $display("FAIL cfg_rd_early: valid got 1 required 0"); end
    tick();
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'hA5) begin n_fail++; $display("FAIL cfg_rd: got v=%b %h required v=1 a5", sr_resp.valid, sr_resp.data); end
    tick();
    n_checks++; if (sr_resp.valid !== 1'b0) begin n_fail++; $display("FAIL cfg_rd_pulse: valid got 1 required 0"); end
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(0, NUM_REGS - 1);
      d   = {$urandom, $urandom};
      send(1'b1, 32'(idx), d);
      send(1'b0, 32'(idx), 64'h0);
      tick();
      n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== d) begin n_fail++; $display("FAIL cfg_rand idx %0d: got v=%b %h required %h", idx, sr_resp.valid, sr_resp.data, d); end
    end
    d = cfg_regs;
    send(1'b1, 32'h0000_0123, 64'hDEAD);
    send(1'b0, 32'h0000_0123, 64'h0);
    tick();
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h0) begin n_fail++; $display("FAIL oor_read: got v=%b %h required v=1 0", sr_resp.valid, sr_resp.data); end
    n_checks++; if (cfg_regs[3] !== 64'hA5 && idx != 3) begin n_fail++; $display("FAIL oor_write: cfg3 got %h required a5", cfg_regs[3]); end
  endtask

  task automatic test_app_write();
    logic [63:0] d = {$urandom, $urandom};
    send(1'b1, 32'h15, d);
    n_checks++; if (app_wr_valid !== 1'b1 || app_wr_idx !== 4'd5 || app_wr_data !== d) begin n_fail++; $display("FAIL app_wr: got v=%b i=%0d %h required v=1 i=5 %h", app_wr_valid, app_wr_idx, app_wr_data, d); end
    tick();
    n_checks++; if (app_wr_valid !== 1'b0) begin n_fail++; $display("FAIL app_wr_pulse: got 1 required 0"); end
  endtask

  task automatic test_app_read();
    send(1'b0, 32'h12, 64'h0);
    wait_app_valid("app_rd_start");
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (app_rd_valid !== 1'b1 || app_rd_idx !== 4'd2 || sr_resp.valid !== 1'b0) begin n_fail++; $display("FAIL app_rd_hold %0d: got v=%b i=%0d r=%b required 1 2 0", k, app_rd_valid, app_rd_idx, sr_resp.valid); end
      if (k < 4) tick();
    end
    app_rd_ack = 1'b1; app_rd_data = 64'h1234;
    tick();
    app_rd_ack = 1'b0;
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h1234 || app_rd_valid !== 1'b0) begin n_fail++; $display("FAIL app_rd_resp: got v=%b %h arv=%b required 1 1234 0", sr_resp.valid, sr_resp.data, app_rd_valid); end
  endtask

  task automatic test_order();
    logic [63:0] d = {$urandom, $urandom};
    send(1'b1, 32'h1, 64'h7);
    send(1'b0, 32'h1A, 64'h0);
    send(1'b0, 32'h1, 64'h0);
    wait_app_valid("order_start");
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (sr_resp.valid !== 1'b0) begin n_fail++; $display("FAIL order_early %0d: valid got 1 required 0", k); end
      tick();
    end
    app_rd_ack = 1'b1; app_rd_data = d;
    tick();
    app_rd_ack = 1'b0;
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== d) begin n_fail++; $display("FAIL order_first: got v=%b %h required %h", sr_resp.valid, sr_resp.data, d); end
    tick();
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h7) begin n_fail++; $display("FAIL order_second: got v=%b %h required 7", sr_resp.valid, sr_resp.data); end
  endtask

  task automatic test_timeout();
    int cnt = 0; int k = 0;
    send(1'b0, 32'h17, 64'h0);
    while (!sr_resp.valid && k < 400) begin
      tick(); k++;
      if (app_rd_valid) cnt++;
    end
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== SR_TIMEOUT_DATA) begin n_fail++; $display("FAIL timeout_resp: got v=%b %h required all-ones", sr_resp.valid, sr_resp.data); end
    n_checks++; if (err_sticky !== 1'b1 || app_rd_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got err=%b arv=%b required 1 0", err_sticky, app_rd_valid); end
    n_checks++; if (cnt < TIMEOUT || cnt > TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_wait: got %0d cycles required %0d..%0d", cnt, TIMEOUT, TIMEOUT + 1); end
  endtask

  task automatic test_drop();
    logic [63:0] d = {$urandom, $urandom};
    do_reset();
    for (int k = 4; k < 10; k++) send(1'b1, 32'(k), 64'h1000 + 64'(k));
    send(1'b0, 32'h18, 64'h0);
    for (int k = 4; k < 10; k++) send(1'b0, 32'(k), 64'h0);
    send(1'b1, 32'h4, 64'hBEEF);
    n_checks++; if (drop_count !== 16'd3 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL drop_count: got %0d err=%b required 3 1", drop_count, err_sticky); end
    n_checks++; if (app_rd_valid !== 1'b1 || app_rd_idx !== 4'd8) begin n_fail++; $display("FAIL drop_app: got v=%b i=%0d required 1 8", app_rd_valid, app_rd_idx); end
    app_rd_ack = 1'b1; app_rd_data = d;
    tick();
    app_rd_ack = 1'b0;
    n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== d) begin n_fail++; $display("FAIL drop_resp0: got v=%b %h required %h", sr_resp.valid, sr_resp.data, d); end
    for (int k = 4; k < 7; k++) begin
      tick();
      n_checks++; if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h1000 + 64'(k)) begin n_fail++; $display("FAIL drop_resp reg%0d: got v=%b %h required %h", k, sr_resp.valid, sr_resp.data, 64'h1000 + 64'(k)); end
    end
    tick();
    n_checks++; if (sr_resp.valid !== 1'b0) begin n_fail++; $display("FAIL drop_extra: valid got 1 required 0"); end
  endtask

  task automatic test_reset_app_wait();
    do_reset();
    send(1'b1, 32'h2, 64'h55);
    send(1'b0, 32'h13, 64'h0);
    wait_app_valid("rst_wait_start");
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (app_rd_valid !== 1'b0 || cfg_regs !== '0 || sr_resp !== '0) begin n_fail++; $display("FAIL async_rst: got arv=%b cfg2=%h resp=%h required 0", app_rd_valid, cfg_regs[2], sr_resp); end
    app_rd_ack = 1'b1; app_rd_data = 64'hABCD;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (sr_resp.valid !== 1'b0 || app_rd_valid !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack %0d: got v=%b arv=%b err=%b required 0 0 0", k, sr_resp.valid, app_rd_valid, err_sticky); end
    end
    app_rd_ack = 1'b0;
  endtask

  task automatic test_random();
    pend_t       exp_q[$];
    pend_t       e;
    logic [63:0] m_cfg [NUM_REGS];
    int          m_drops = 0;
    bit          m_err = 0;
    bit          req_v, req_w, oor, reg_app, ack_now, waiting, done, wr_exp;
    logic [31:0] req_a;
    logic [63:0] req_d, ack_data, exp_d;
    int          idx, delay, i;
    do_reset();
    for (int k = 0; k < NUM_REGS; k++) m_cfg[k] = '0;
    ack_now = 0; waiting = 0; done = 0; delay = 0; i = 0; ack_data = '0;
    while (!done) begin
      req_v = (i < N_RAND) && ($urandom_range(0, 9) < 7);
      req_w = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: req_a = 32'($urandom_range(0, 15));
        3, 4:    req_a = 32'h10 | 32'($urandom_range(0, 15));
        default: req_a = $urandom | 32'h20;
      endcase
      req_d = {$urandom, $urandom};
      sr_req.valid = req_v; sr_req.isWrite = req_w; sr_req.addr = req_a; sr_req.data = req_d;
      tick();
      app_rd_ack = 1'b0;
      oor = (req_a[31:5] != 0); reg_app = req_a[4]; idx = int'(req_a[3:0]);
      if (sr_resp.valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_resp: unexpected response %h at cycle %0d", sr_resp.data, i);
        end else begin
          e = exp_q.pop_front();
          exp_d = e.is_app ? ack_data : e.data;
          if (sr_resp.data !== exp_d || (e.is_app && !ack_now)) begin n_fail++; $display("FAIL rand_resp cycle %0d: got %h required %h (app=%0d ack=%0d)", i, sr_resp.data, exp_d, e.is_app, ack_now); end
        end
      end else if (ack_now) begin
        n_checks++; n_fail++; $display("FAIL rand_ack_resp cycle %0d: got no response required %h", i, ack_data);
      end
      wr_exp = req_v && req_w && !oor && reg_app;
      n_checks++;
      if (app_wr_valid !== wr_exp || (wr_exp && (app_wr_idx !== req_a[3:0] || app_wr_data !== req_d))) begin
        n_fail++; $display("FAIL rand_app_wr cycle %0d: got v=%b i=%0d %h required v=%b i=%0d %h", i, app_wr_valid, app_wr_idx, app_wr_data, wr_exp, idx, req_d);
      end
      if (req_v && req_w && !oor && !reg_app) m_cfg[idx] = req_d;
      if (req_v && !req_w) begin
        if (exp_q.size() < DEPTH) begin
          e.is_app = !oor && reg_app; e.idx = idx;
          e.data = (!oor && !reg_app) ? m_cfg[idx] : 64'h0;
          exp_q.push_back(e);
        end else begin
          m_err = 1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
      end
      n_checks++;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (cfg_regs[k] !== m_cfg[k]) begin n_fail++; $display("FAIL rand_cfg cycle %0d reg %0d: got %h required %h", i, k, cfg_regs[k], m_cfg[k]); break; end
      end
      n_checks++;
      if (drop_count !== 16'(m_drops) || err_sticky !== m_err) begin n_fail++; $display("FAIL rand_drop cycle %0d: got %0d err=%b required %0d err=%b", i, drop_count, err_sticky, m_drops, m_err); end
      ack_now = 0;
      if (app_rd_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_app || app_rd_idx !== 4'(exp_q[0].idx)) begin n_fail++; $display("FAIL rand_app_rd cycle %0d: got idx %0d with no matching app head", i, app_rd_idx); end
        if (!waiting) begin waiting = 1; delay = $urandom_range(0, 6); end
        if (delay == 0) begin
          app_rd_ack = 1'b1; app_rd_data = {$urandom, $urandom};
          ack_data = app_rd_data; ack_now = 1; waiting = 0;
        end else delay--;
      end
      i++;
      if (i >= N_RAND && exp_q.size() == 0 && !waiting && !ack_now) done = 1;
      if (i >= N_RAND + 300) begin
        n_checks++; n_fail++; $display("FAIL rand_drain: got %0d pending required 0", exp_q.size());
        done = 1;
      end
    end
    sr_req = '0; app_rd_ack = 1'b0;
  endtask

  initial begin
    sr_req = '0;
    test_reset();
    test_config();
    test_app_write();
    test_app_read();
    test_order();
    test_timeout();
    test_drop();
    test_reset_app_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aos_sr_responder.md
Name: aos_sr_responder

Overview:
- App-side endpoint of the AmorphOS SoftReg channel. It consumes the per-app SoftRegReq stream produced by the request route tree and produces the SoftRegResp stream merged by the response route tree.
- Holds a bank of host-writable config registers and forwards reads/writes of an app region to the application over a variable-latency handshake.
- Returns read responses strictly in request order, one per cycle maximum. The SoftReg channel has no backpressure, so reads are buffered internally.

Parameters:
NUM_REGS, 16, number of 64-bit config registers and app-region indices; power of two, >=2
PEND_LOG_DEPTH, 2, log2 depth of pending-read queue
APP_TIMEOUT, 255, max cycles to wait for app_rd_ack before an error response

Ports:
clk  in  1  user clock
rst  in  1  reset, asynchronous, active-high
sr_req  in  SoftRegReq  request from route tree (valid, isWrite, addr[31:0], data[63:0])
sr_resp  out  SoftRegResp  response to route tree (valid, data[63:0])
cfg_regs  out  NUM_REGS x 64  config register contents
app_wr_valid  out  1  one-cycle pulse: write to app region
app_wr_idx  out  IDX_W  app-region index (IDX_W = $clog2(NUM_REGS))
app_wr_data  out  64  write data
app_rd_valid  out  1  level; app read outstanding
app_rd_idx  out  IDX_W  app read index; stable while app_rd_valid
app_rd_ack  in  1  app read complete; sampled only while app_rd_valid=1
app_rd_data  in  64  read data, valid with app_rd_ack
err_sticky  out  1  set on timeout or dropped read; cleared only by reset
drop_count  out  16  saturating count of dropped reads

Behaviour:
- Reset (async assert): cfg_regs=0, sr_resp.valid=0, sr_resp.data=0, app_wr_valid=0, app_rd_valid=0, err_sticky=0, drop_count=0. Pending queue is emptied and the FSM goes to IDLE. Any outstanding app read is abandoned; an ack arriving after reset is ignored.
- Decode on a cycle with sr_req.valid:
  - idx = addr[IDX_W-1:0]; region bit = addr[IDX_W].
  - addr[31:IDX_W+1] != 0 means out of range.
  - region 0 = CONFIG, region 1 = APP.
- Writes, accepted every cycle with no queueing:
  - CONFIG: cfg_regs[idx] <= data, visible on the next cycle.
  - APP: app_wr_valid/idx/data registered, pulse on cycle N+1.
  - Out of range: ignored.
- Reads enqueue entry {kind, idx, snap} into the pending FIFO:
  - CONFIG: kind=LOCAL, snap=cfg_regs[idx] sampled at acceptance, so a later write does not affect an earlier read.
  - Out of range: kind=LOCAL, snap=0.
  - APP: kind=APP.
- Pending FIFO full on a read: the read is dropped, err_sticky<=1, drop_count+1 (saturating at 0xFFFF). Writes are never affected by a full FIFO.
- Response FSM, states IDLE and APP_WAIT:
  - IDLE, head LOCAL: pop; sr_resp.valid<=1, data<=snap.
  - IDLE, head APP: app_rd_valid<=1, app_rd_idx<=idx, timer<=0, go to APP_WAIT. No pop yet.
  - APP_WAIT, app_rd_ack=1: pop; sr_resp.valid<=1, data<=app_rd_data; app_rd_valid<=0; go to IDLE.
  - APP_WAIT, timer==APP_TIMEOUT without ack: pop; sr_resp.valid<=1, data<=64'hFFFF_FFFF_FFFF_FFFF; err_sticky<=1; app_rd_valid<=0; go to IDLE.
  - sr_resp.valid is a one-cycle pulse per response; otherwise 0.
- Latency and throughput:
  - Local read accepted at cycle N with queue empty and FSM IDLE: sr_resp.valid at N+2.
  - Back-to-back local reads produce one response per cycle.
  - App read: sr_resp.valid one cycle after the ack cycle.
  - At most one app read outstanding at a time.
- Simultaneous events:
  - Enqueue and pop in the same cycle are legal on a full FIFO: the pop frees the slot, so the read is accepted.
  - Write and read to the same CONFIG idx cannot occur in one cycle (single request per cycle).
  - Ack arriving on the same cycle as the timeout match: the ack wins and real data is returned.

Decomposition:
- AOSF1Types additions:
  - sr_region_t enum {SR_CONFIG, SR_APP}
  - sr_resp_state_t enum {SR_IDLE, SR_APP_WAIT}
  - SRPendEntry struct {isApp, idx, snap[63:0]}
  - SR_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF
- Pending queue is a HullFIFO instance (WIDTH=$bits(SRPendEntry), LOG_DEPTH=PEND_LOG_DEPTH).
- No further sub-module.

Test Plan:
- Write addr 0x3 data 0xA5 then read addr 0x3 -> cfg_regs[3]=0xA5 next cycle; sr_resp.valid 2 cycles after the read, data 0xA5.
- Read addr 0x12 (APP idx 2), app acks after 5 cycles with 0x1234 -> app_rd_idx=2 held for 5 cycles; sr_resp.data=0x1234 one cycle after ack.
- APP read then CONFIG read of reg 1 (=0x7), app ack after 10 cycles -> responses in order: app data first, then 0x7; no response before the ack.
- APP read with no ack -> after 255 wait cycles sr_resp.data=all-ones, err_sticky=1, app_rd_valid=0.
- Stalled APP read plus 6 further reads, depth 4 -> 3 dropped, drop_count=3, err_sticky=1; the 4 queued reads respond in order after the ack.
- Assert rst during APP_WAIT, then ack -> outputs at reset values, no sr_resp.valid, cfg_regs=0.
